sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; successor to the dual-clock FIFO.
- Generalised width and depth, explicit write/read handshakes, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags.
- Sits between the transmitter data source and the downstream consumer when both share one clock domain; no pointer synchronisers needed.

Parameters:
- W, 16, data word width in bits
- P, 5, address width; DEPTH = 1<<P (default 32 words)
- AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- write_en  in  1  write request
- data_in  in  W  write data
- read_en  in  1  read request
- data_out  out  W  read data
- data_valid  out  1  data_out holds a freshly popped word
- w_full  out  1  FIFO holds DEPTH words
- r_empty  out  1  FIFO holds 0 words
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  P+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

Behaviour:
- One clock (clk). reset is synchronous and active-high, sampled on the rising edge of clk only.
- Pointers: wr_ptr and rd_ptr are P+1 bits. Memory is indexed by [P-1:0]; the MSB is the wrap bit.
- Pointers wrap naturally modulo 2^(P+1).
- Flags:
  - r_empty = (wr_ptr == rd_ptr).
  - w_full = (wr_ptr[P] != rd_ptr[P]) && (wr_ptr[P-1:0] == rd_ptr[P-1:0]).
  - count = wr_ptr - rd_ptr, modulo 2^(P+1).
  - All flags and count are combinational from registered pointers, so they update in the cycle after the accepting edge.
- Write accept: write_en && !w_full. Stores memory[wr_ptr[P-1:0]] <= data_in and increments wr_ptr.
- Read accept: read_en && !r_empty. Increments rd_ptr.
- Simultaneous write and read accepts: both occur and count is unchanged.
- When full: the read is accepted; the write is rejected and sets overflow. The flag decision uses pre-edge state.
- When empty: the write is accepted; the read is rejected and sets underflow. There is no write-through.
- Standard (registered) read:
  - On an accepted read at edge N, data_out = memory[rd_ptr] and data_valid = 1 after edge N.
  - data_valid = 0 after any edge without an accepted read.
  - data_out holds its last value when no read is accepted.
- overflow and underflow: set on the offending edge; cleared only by reset.
- Reset values: wr_ptr = rd_ptr = 0, count = 0, r_empty = 1, w_full = 0, almost_empty = 1, almost_full = 0 (AF_LEVEL > 0), data_out = 0, data_valid = 0, overflow = 0, underflow = 0. Memory contents are not reset.
- Reset mid-operation discards all stored words. write_en and read_en are ignored on the reset edge.
- Thresholds are compared against count exactly. AE_LEVEL = 0 makes almost_empty equal r_empty.
- Parameter legality: P >= 1; 0 < AF_LEVEL <= DEPTH; AE_LEVEL < DEPTH. Illegal values stop elaboration.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN (first-word-fall-through).
- Defined:
  - data_out = memory[rd_ptr[P-1:0]] combinationally; the head word is visible whenever r_empty = 0.
  - read_en acknowledges (pops) the head word.
  - data_valid = !r_empty.
  - Read latency is 0 cycles.
- Undefined: the standard registered read described above, with 1-cycle latency.
- Flags, count, and error flags are identical in both modes.

Decomposition:
- Package sync_fifo_pkg:
  - ptr_t width helper (P+1).
  - Function computing DEPTH from P.
  - Default-threshold constants.
- Sub-module fifo_dpram:
  - W x DEPTH memory with synchronous write and asynchronous read port.
  - Reused for the FWFT head path; the registered read stage lives in the top level.

Test Plan:
- Reset, then write 0,5,10,... (word z = z*5) for 32 cycles with read_en = 0 → count steps 1..32; almost_full asserts at count 28; w_full = 1 after the 32nd write; overflow stays 0.
- From full, a 33rd write_en with data 0xFFFF → rejected; overflow = 1; count stays 32; the next read returns 0 (not 0xFFFF).
- Drain a full FIFO with read_en = 1 for 32 cycles → data_out sequence 0,5,...,155, each one cycle after its accept (0 cycles under FWFT); r_empty = 1 after the last; almost_empty asserts at count 4.
- Read on empty → underflow = 1, data_valid = 0, rd_ptr unchanged; underflow stays set until reset.
- Continuous simultaneous write/read at count 3 for 100 cycles → count constant at 3; pointers wrap past 63→0 without data loss; data ordering preserved.
- Assert reset at count 17 mid-stream → the next cycle shows count 0, r_empty = 1, data_valid = 0, overflow = 0, underflow = 0; a subsequent write/read round-trips 0x1234.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and default thresholds for the single-clock FIFO.
package sync_fifo_pkg;

    localparam int DEF_W         = 16;
    localparam int DEF_P         = 5;
    localparam int DEF_AF_MARGIN = 4;
    localparam int DEF_AE_LEVEL  = 4;

    typedef logic [DEF_P:0] ptr_t;

    function automatic int fifo_depth(input int p);
        return 1 << p;
    endfunction

    // Pointers carry one extra wrap bit beyond the memory index.
    function automatic int ptr_width(input int p);
        return p + 1;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// W x DEPTH storage: synchronous write port, asynchronous read port.
module fifo_dpram
    import sync_fifo_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int P = DEF_P
) (
    input  logic         clk,
    input  logic         wr_en,
    input  logic [P-1:0] wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic [P-1:0] rd_addr,
    output logic [W-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(P);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int P        = DEF_P,
    parameter int AF_LEVEL = fifo_depth(P) - DEF_AF_MARGIN,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         write_en,
    input  logic [W-1:0] data_in,
    input  logic         read_en,
    output logic [W-1:0] data_out,
    output logic         data_valid,
    output logic         w_full,
    output logic         r_empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [P:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam int DEPTH = fifo_depth(P);
    localparam int PW    = ptr_width(P);
    localparam logic [PW-1:0] AF_THR = AF_LEVEL[PW-1:0];
    localparam logic [PW-1:0] AE_THR = AE_LEVEL[PW-1:0];

    if (P < 1 || AF_LEVEL <= 0 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_params
        $error("sync_fifo_param: illegal P/AF_LEVEL/AE_LEVEL combination");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_acc, rd_acc;
    logic [W-1:0]  head;

    assign r_empty      = (wr_ptr_q == rd_ptr_q);
    assign w_full       = (wr_ptr_q[P] != rd_ptr_q[P]) && (wr_ptr_q[P-1:0] == rd_ptr_q[P-1:0]);
    assign count        = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (count >= AF_THR);
    assign almost_empty = (count <= AE_THR);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Accept decisions use pre-edge flags, so a full FIFO still pops on a read.
    assign wr_acc = write_en && !w_full;
    assign rd_acc = read_en && !r_empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q  | (write_en && w_full);
        underflow_d = underflow_q | (read_en && r_empty);
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_dpram #(
        .W (W),
        .P (P)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc && !reset),
        .wr_addr (wr_ptr_q[P-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q[P-1:0]),
        .rd_data (head)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out   = head;
    assign data_valid = !r_empty;
`else
    logic [W-1:0] data_out_q, data_out_d;
    logic         data_valid_q, data_valid_d;

    always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = rd_acc;
        if (rd_acc) begin
            data_out_d = head;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (default registered-read build, W=16, P=5).
module tb_sync_fifo_param;

    localparam int DEPTH = 32;
    localparam int AF    = 28;
    localparam int AE    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_en;
    logic [15:0] data_in;
    logic        read_en;
    logic [15:0] data_out;
    logic        data_valid;
    logic        w_full;
    logic        r_empty;
    logic        almost_full;
    logic        almost_empty;
    logic [5:0]  count;
    logic        overflow;
    logic        underflow;

    sync_fifo_param dut (
        .clk          (clk),
        .reset        (reset),
        .write_en     (write_en),
        .data_in      (data_in),
        .read_en      (read_en),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .w_full       (w_full),
        .r_empty      (r_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of stored words plus the observable read-side registers.
    logic [15:0] q[$];
    logic [15:0] m_dout;
    logic        m_dv;
    logic        m_ovf;
    logic        m_unf;

    typedef struct {
        logic        we;
        logic [15:0] din;
        logic        re;
        int          exp_count;
        logic        exp_dv;
        logic [15:0] exp_dout;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("count",        32'(count),        32'(q.size()));
        chk("r_empty",      32'(r_empty),      32'(q.size() == 0));
        chk("w_full",       32'(w_full),       32'(q.size() == DEPTH));
        chk("almost_full",  32'(almost_full),  32'(q.size() >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
        chk("data_valid",   32'(data_valid),   32'(m_dv));
        chk("data_out",     32'(data_out),     32'(m_dout));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_unf));
    endtask

    task automatic step(input logic we, input logic [15:0] din, input logic re, input logic rst);
        bit full, empty;
        write_en = we;
        data_in  = din;
        read_en  = re;
        reset    = rst;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_dout = '0;
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            full  = (q.size() == DEPTH);
            empty = (q.size() == 0);
            if (we && full) m_ovf = 1'b1;
            if (re && empty) m_unf = 1'b1;
            m_dv = re && !empty;
            if (m_dv) m_dout = q.pop_front();
            if (we && !full) q.push_back(din);
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        step(1'b1, 16'hDEAD, 1'b1, 1'b1);
    endtask

    initial begin
        reset    = 1'b1;
        write_en = 1'b0;
        read_en  = 1'b0;
        data_in  = '0;

        vecs[0] = '{1'b1, 16'h00A1, 1'b0, 1, 1'b0, 16'h0000};
        vecs[1] = '{1'b1, 16'h00B2, 1'b0, 2, 1'b0, 16'h0000};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1, 1'b1, 16'h00A1};
        vecs[3] = '{1'b1, 16'h00C3, 1'b1, 1, 1'b1, 16'h00B2};
        vecs[4] = '{1'b0, 16'h0000, 1'b0, 1, 1'b0, 16'h00B2};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 0, 1'b1, 16'h00C3};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 0, 1'b0, 16'h00C3};
        vecs[7] = '{1'b1, 16'h00D4, 1'b1, 1, 1'b0, 16'h00C3};
        vecs[8] = '{1'b0, 16'h0000, 1'b1, 0, 1'b1, 16'h00D4};

        do_reset();
        do_reset();

        // Table-driven short sequence, including empty-read and no write-through.
        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].din, vecs[i].re, 1'b0);
            chk("tbl_count", 32'(count),      32'(vecs[i].exp_count));
            chk("tbl_dv",    32'(data_valid), 32'(vecs[i].exp_dv));
            chk("tbl_dout",  32'(data_out),   32'(vecs[i].exp_dout));
        end
        chk("tbl_underflow", 32'(underflow), 32'd1);

        // Fill to full with z*5.
        do_reset();
        for (int z = 0; z < DEPTH; z++) begin
            step(1'b1, 16'(z * 5), 1'b0, 1'b0);
            chk("fill_count", 32'(count), 32'(z + 1));
            chk("fill_af",    32'(almost_full), 32'(z + 1 >= 28));
        end
        chk("fill_full", 32'(w_full), 32'd1);
        chk("fill_ovf",  32'(overflow), 32'd0);

        // Write while full is rejected.
        step(1'b1, 16'hFFFF, 1'b0, 1'b0);
        chk("ovf_set",   32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd32);

        // Drain: each word appears one cycle after its accepting edge.
        for (int z = 0; z < DEPTH; z++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0);
            chk("drain_dout", 32'(data_out), 32'(z * 5));
            chk("drain_dv",   32'(data_valid), 32'd1);
            chk("drain_ae",   32'(almost_empty), 32'(DEPTH - 1 - z <= 4));
        end
        chk("drain_empty", 32'(r_empty), 32'd1);

        // Read on empty.
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("unf_set", 32'(underflow), 32'd1);
        chk("unf_dv",  32'(data_valid), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("unf_sticky", 32'(underflow), 32'd1);

        // Simultaneous write/read at count 3; pointers wrap past 63.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 16'($urandom), 1'b1, 1'b0);
            chk("steady_count", 32'(count), 32'd3);
        end

        // Reset mid-stream at count 17.
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd17);
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(r_empty), 32'd1);
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("rt_dout", 32'(data_out), 32'h1234);

        // Randomized traffic against the model with varying fill bias.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int wbias;
            wbias = (i / 300) % 2 ? 30 : 70;
            step(1'($urandom_range(99) < wbias), 16'($urandom),
                 1'($urandom_range(99) < 100 - wbias), 1'($urandom_range(499) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
